ahb_cmd_fifo_writer: RTL

//  AHB-Lite slave front end, wr_clk domain. Producer of the AHB->SPI command async FIFO and

---
 rtl/ahb_cmd_fifo_writer_if.sv | 23 ++
 rtl/ahb_cmd_fifo_writer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/ahb_cmd_fifo_writer_if.sv
// AHB-Lite bus bundle between a master and the command-FIFO writer slave.
interface ahb_cmd_fifo_writer_if;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic        hready;
    logic        hreadyout;
    logic        hresp;
    logic [31:0] hrdata;

    modport slave (
        input  hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
        output hreadyout, hresp, hrdata
    );

    modport master (
        output hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
        input  hreadyout, hresp, hrdata
    );
endinterface

// File: rtl/ahb_cmd_fifo_writer.sv
// AHB-Lite slave that packs transfers into command-FIFO words and stalls reads for responses.
// Optional READ_TIMEOUT_EN: RD_WAIT timeout to ERROR plus discard of late responses in IDLE.
module ahb_cmd_fifo_writer #(
    parameter int CMD_ADDR_W = 8,
    parameter int CMD_W      = 1 + CMD_ADDR_W + 32,
    parameter int RD_TIMEOUT = 1024
) (
    input  logic                 wr_clk,
    input  logic                 wr_rst,
    ahb_cmd_fifo_writer_if.slave ahb,
    output logic                 fifo_wr_en_o,
    output logic [CMD_W-1:0]     fifo_wr_data_o,
    input  logic                 fifo_full_i,
    output logic                 rsp_rd_en_o,
    input  logic [31:0]          rsp_data_i,
    input  logic                 rsp_empty_i
);

    typedef enum logic [2:0] {
        IDLE, WR_DATA, RD_PUSH, RD_WAIT, RD_DONE, ERR1, ERR2
    } state_t;

    state_t                state_q, state_d;
    logic [CMD_ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]           hrdata_q, hrdata_d;

    logic        accept;
    logic        xfer_err;
    logic        take_new;
    logic        hready_out;
    logic        hresp_out;
    logic        push;
    logic        pop;
    logic [31:0] cmd_lo;
    state_t      decoded;

`ifdef READ_TIMEOUT_EN
    localparam int TMR_W = $clog2(RD_TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(RD_TIMEOUT - 1);

    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [7:0]       discard_q, discard_d;
`endif

    assign accept   = ahb.hsel & ahb.htrans[1] & ahb.hready;
    assign xfer_err = (ahb.hsize != 3'b010) | (ahb.haddr[1:0] != 2'b00);
    assign decoded  = xfer_err ? ERR1 : (ahb.hwrite ? WR_DATA : RD_PUSH);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        hrdata_d   = hrdata_q;
        hready_out = 1'b1;
        hresp_out  = 1'b0;
        push       = 1'b0;
        pop        = 1'b0;
        cmd_lo     = 32'h0;
        take_new   = 1'b0;
`ifdef READ_TIMEOUT_EN
        tmr_d      = tmr_q;
        discard_d  = discard_q;
`endif
        case (state_q)
            IDLE: begin
                take_new = 1'b1;
`ifdef READ_TIMEOUT_EN
                if (discard_q != 8'd0 && !rsp_empty_i) begin
                    pop       = 1'b1;
                    discard_d = discard_q - 8'd1;
                end
`endif
            end
            WR_DATA: begin
                if (fifo_full_i) begin
                    hready_out = 1'b0;
                end else begin
                    push     = 1'b1;
                    cmd_lo   = ahb.hwdata;
                    take_new = 1'b1;
                    state_d  = IDLE;
                end
            end
            RD_PUSH: begin
                hready_out = 1'b0;
                if (!fifo_full_i) begin
                    push    = 1'b1;
                    state_d = RD_WAIT;
`ifdef READ_TIMEOUT_EN
                    tmr_d   = TMR_LOAD;
`endif
                end
            end
            RD_WAIT: begin
                hready_out = 1'b0;
`ifdef READ_TIMEOUT_EN
                if (!rsp_empty_i) begin
                    pop = 1'b1;
                    // stale words from earlier timed-out reads drain before our own
                    if (discard_q != 8'd0) begin
                        discard_d = discard_q - 8'd1;
                    end else begin
                        hrdata_d = rsp_data_i;
                        state_d  = RD_DONE;
                    end
                end else if (tmr_q == '0) begin
                    state_d = ERR1;
                    if (discard_q != 8'hFF) discard_d = discard_q + 8'd1;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
`else
                if (!rsp_empty_i) begin
                    pop      = 1'b1;
                    hrdata_d = rsp_data_i;
                    state_d  = RD_DONE;
                end
`endif
            end
            RD_DONE: begin
                take_new = 1'b1;
                state_d  = IDLE;
            end
            ERR1: begin
                hready_out = 1'b0;
                hresp_out  = 1'b1;
                state_d    = ERR2;
            end
            ERR2: begin
                hresp_out = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (take_new && accept) begin
            state_d = decoded;
            addr_d  = ahb.haddr[CMD_ADDR_W+1:2];
        end
    end

    always_ff @(posedge wr_clk or posedge wr_rst) begin
        if (wr_rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            hrdata_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            hrdata_q <= hrdata_d;
        end
    end

`ifdef READ_TIMEOUT_EN
    always_ff @(posedge wr_clk or posedge wr_rst) begin
        if (wr_rst) begin
            tmr_q     <= '0;
            discard_q <= 8'd0;
        end else begin
            tmr_q     <= tmr_d;
            discard_q <= discard_d;
        end
    end
`endif

    assign ahb.hreadyout  = hready_out;
    assign ahb.hresp      = hresp_out;
    assign ahb.hrdata     = hrdata_q;
    assign fifo_wr_en_o   = push;
    assign fifo_wr_data_o = {state_q == WR_DATA, addr_q, cmd_lo};
    assign rsp_rd_en_o    = pop;

    logic unused_ok;
    assign unused_ok = ^{ahb.haddr[31:CMD_ADDR_W+2], ahb.htrans[0], RD_TIMEOUT == 0};

endmodule
